err_service_sched: RTL and testbench

//  Sequencer for the error-priority datapath. Latches incoming error pulses into sticky pending bits.

---
 rtl/err_service_sched.sv | 129 ++++++++++++
 tb/tb_err_service_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/err_service_sched.sv
// Error service sequencer: sticky capture of error pulses, priority arbitration over pending sources,
// and one-at-a-time presentation of the winning index to the service agent over valid/ready.
module err_service_sched #(
  parameter int N_ERR  = 32,
  parameter int PRIO_W = 5,
  parameter int ID_W   = $clog2(N_ERR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_ERR-1:0]  err_in,
  input  logic [N_ERR-1:0]  err_mask,
  input  logic              cfg_wr_en,
  input  logic [ID_W-1:0]   cfg_wr_idx,
  input  logic [PRIO_W-1:0] cfg_wr_prio,
  input  logic              clr_all,
  output logic              svc_valid,
  output logic [ID_W-1:0]   svc_id,
  output logic [PRIO_W-1:0] svc_prio,
  input  logic              svc_ready,
  output logic [N_ERR-1:0]  pending,
  output logic              ovf
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     svc_id_q, svc_id_d;
  logic [PRIO_W-1:0]   svc_prio_q, svc_prio_d;
  logic [N_ERR-1:0]    pending_q, pending_d;
  logic                ovf_q, ovf_d;

  logic [PRIO_W-1:0]   prio_vec [N_ERR];
  logic [N_ERR-1:0]    set_vec, clr_vec, elig;
  logic                accept;
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [PRIO_W-1:0]   win_prio;

  // Priority table: each entry resets to its own index and reverts to it on every reset.
  for (genvar gi = 0; gi < N_ERR; gi++) begin : g_prio
    localparam logic [PRIO_W-1:0] RST_PRIO = PRIO_W'(gi % (1 << PRIO_W));
    logic [PRIO_W-1:0] prio_entry_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prio_entry_q <= RST_PRIO;
      end else if (cfg_wr_en && (cfg_wr_idx == ID_W'(gi))) begin
        prio_entry_q <= cfg_wr_prio;
      end
    end

    assign prio_vec[gi] = prio_entry_q;
  end

  assign accept  = (state_q == PRESENT) && svc_ready;
  assign set_vec = err_in & ~err_mask;
  assign clr_vec = accept ? ({{(N_ERR-1){1'b0}}, 1'b1} << svc_id_q) : '0;
  assign elig    = pending_q & ~err_mask;

  // Strict greater-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_prio  = '0;
    for (int i = 0; i < N_ERR; i++) begin
      if (elig[i] && (!win_found || (prio_vec[i] > win_prio))) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
        win_prio  = prio_vec[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    svc_id_d   = svc_id_q;
    svc_prio_d = svc_prio_q;
    pending_d  = (pending_q & ~clr_vec) | set_vec;
    ovf_d      = ovf_q | (|(set_vec & pending_q & ~clr_vec));

    case (state_q)
      IDLE: begin
        if (win_found) begin
          svc_id_d   = win_id;
          svc_prio_d = win_prio;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_all) begin
      state_d   = IDLE;
      pending_d = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      svc_id_q   <= '0;
      svc_prio_q <= '0;
      pending_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      svc_id_q   <= svc_id_d;
      svc_prio_q <= svc_prio_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
    end
  end

  assign svc_valid = (state_q == PRESENT);
  assign svc_id    = svc_id_q;
  assign svc_prio  = svc_prio_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_err_service_sched.sv
// Directed bench for err_service_sched: capture, arbitration order, ties, overflow, masking,
// flush and asynchronous reset, with hand-computed expectations checked by immediate assertions.
module tb_err_service_sched;

  localparam int N_ERR  = 32;
  localparam int PRIO_W = 5;
  localparam int ID_W   = 5;

  logic              clk;
  logic              rst_n;
  logic [N_ERR-1:0]  err_in;
  logic [N_ERR-1:0]  err_mask;
  logic              cfg_wr_en;
  logic [ID_W-1:0]   cfg_wr_idx;
  logic [PRIO_W-1:0] cfg_wr_prio;
  logic              clr_all;
  logic              svc_valid;
  logic [ID_W-1:0]   svc_id;
  logic [PRIO_W-1:0] svc_prio;
  logic              svc_ready;
  logic [N_ERR-1:0]  pending;
  logic              ovf;

  int n_checks;
  int n_fail;

  err_service_sched #(.N_ERR(N_ERR), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .err_in      (err_in),
    .err_mask    (err_mask),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_idx  (cfg_wr_idx),
    .cfg_wr_prio (cfg_wr_prio),
    .clr_all     (clr_all),
    .svc_valid   (svc_valid),
    .svc_id      (svc_id),
    .svc_prio    (svc_prio),
    .svc_ready   (svc_ready),
    .pending     (pending),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      $display("check %-18s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input string tag, input int id, input int prio);
    check({tag, "_valid"}, 32'(svc_valid), 32'd1);
    check({tag, "_id"},    32'(svc_id),    32'(id));
    check({tag, "_prio"},  32'(svc_prio),  32'(prio));
  endtask

  task automatic wr_prio(input int idx, input int prio);
    cfg_wr_en   = 1'b1;
    cfg_wr_idx  = ID_W'(idx);
    cfg_wr_prio = PRIO_W'(prio);
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    err_in      = '0;
    err_mask    = '0;
    cfg_wr_en   = 1'b0;
    cfg_wr_idx  = '0;
    cfg_wr_prio = '0;
    clr_all     = 1'b0;
    svc_ready   = 1'b0;
    #22;
    check("rst_valid",   32'(svc_valid), 32'd0);
    check("rst_id",      32'(svc_id),    32'd0);
    check("rst_prio",    32'(svc_prio),  32'd0);
    check("rst_pending", pending,        32'd0);
    check("rst_ovf",     32'(ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: single error, two-edge latency, cleared on accept
    err_in[5] = 1'b1;
    svc_ready = 1'b1;
    tick();
    err_in = '0;
    check("t1_pend_set", pending, 32'h0000_0020);
    check("t1_val_e0",   32'(svc_valid), 32'd0);
    tick();
    present("t1", 5, 5);
    tick();
    check("t1_val_acc",  32'(svc_valid), 32'd0);
    check("t1_pend_clr", pending, 32'd0);

    // 2: three simultaneous errors, prio[3]=31 -> order 3, 20, 7 with idle gaps
    wr_prio(3, 31);
    err_in = 32'h0010_0088;
    tick();
    err_in = '0;
    check("t2_pend", pending, 32'h0010_0088);
    tick();
    present("t2a", 3, 31);
    tick();
    check("t2_gap1", 32'(svc_valid), 32'd0);
    check("t2_pend1", pending, 32'h0010_0080);
    tick();
    present("t2b", 20, 20);
    tick();
    check("t2_gap2", 32'(svc_valid), 32'd0);
    tick();
    present("t2c", 7, 7);
    tick();
    check("t2_gap3", 32'(svc_valid), 32'd0);
    check("t2_pend3", pending, 32'd0);

    // 3: tie at priority 10 between 4 and 9, held while not ready
    wr_prio(4, 10);
    wr_prio(9, 10);
    svc_ready = 1'b0;
    err_in = 32'h0000_0210;
    tick();
    err_in = '0;
    tick();
    present("t3a", 4, 10);
    for (int k = 0; k < 5; k++) begin
      tick();
      present("t3_hold", 4, 10);
    end
    svc_ready = 1'b1;
    tick();
    check("t3_gap", 32'(svc_valid), 32'd0);
    check("t3_pend", pending, 32'h0000_0200);
    tick();
    present("t3b", 9, 10);
    tick();
    check("t3_done", pending, 32'd0);

    // 4a: re-fire in the accept cycle -> pending kept, no ovf, re-presented
    svc_ready = 1'b0;
    err_in[2] = 1'b1;
    tick();
    err_in = '0;
    tick();
    present("t4a", 2, 2);
    svc_ready = 1'b1;
    err_in[2] = 1'b1;
    tick();
    err_in = '0;
    svc_ready = 1'b0;
    check("t4a_gap",  32'(svc_valid), 32'd0);
    check("t4a_pend", pending, 32'h0000_0004);
    check("t4a_ovf",  32'(ovf), 32'd0);
    tick();
    present("t4a_re", 2, 2);
    // 4b: re-fire while pending and unaccepted -> sticky ovf
    err_in[2] = 1'b1;
    tick();
    err_in = '0;
    check("t4b_ovf", 32'(ovf), 32'd1);
    tick();
    check("t4b_ovf_hold", 32'(ovf), 32'd1);
    svc_ready = 1'b1;
    tick();
    svc_ready = 1'b0;
    check("t4b_pend", pending, 32'd0);
    tick();
    check("t4b_ovf_stk", 32'(ovf), 32'd1);

    // 5: masked source is not captured; mask on presented id does not retract it
    err_mask[6] = 1'b1;
    err_in[6]   = 1'b1;
    tick();
    err_in = '0;
    tick();
    check("t5_pend6", pending, 32'd0);
    check("t5_noval", 32'(svc_valid), 32'd0);
    err_mask = '0;
    err_in[11] = 1'b1;
    tick();
    err_in = '0;
    tick();
    present("t5a", 11, 11);
    err_mask[11] = 1'b1;
    tick();
    present("t5_masked", 11, 11);
    svc_ready = 1'b1;
    tick();
    svc_ready = 1'b0;
    err_mask  = '0;
    check("t5_gap",  32'(svc_valid), 32'd0);
    check("t5_pend", pending, 32'd0);

    // 6: clr_all during PRESENT flushes everything, same-cycle err_in discarded
    err_in = 32'h0000_7000;
    tick();
    err_in = '0;
    tick();
    present("t6a", 14, 14);
    clr_all = 1'b1;
    err_in[15] = 1'b1;
    tick();
    clr_all = 1'b0;
    err_in  = '0;
    check("t6_valid", 32'(svc_valid), 32'd0);
    check("t6_pend",  pending, 32'd0);
    check("t6_ovf",   32'(ovf), 32'd0);
    tick();
    check("t6_idle",  32'(svc_valid), 32'd0);
    err_in[1] = 1'b1;
    tick();
    err_in = '0;
    tick();
    present("t6b", 1, 1);
    svc_ready = 1'b1;
    tick();
    svc_ready = 1'b0;
    check("t6_pend1", pending, 32'd0);

    // 7: asynchronous reset mid-handshake, prio table reverts (prio[3] back to 3 < prio[4]=4)
    err_in[8] = 1'b1;
    tick();
    err_in = '0;
    tick();
    present("t7a", 8, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_valid", 32'(svc_valid), 32'd0);
    check("t7_id",    32'(svc_id),    32'd0);
    check("t7_pend",  pending,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    err_in = 32'h0000_0018;
    tick();
    err_in = '0;
    tick();
    present("t7b", 4, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
